serial_le_cmp: RTL and testbench

- Sequential signed magnitude comparator. Produces the `a <= b` result and related flags for two integer operands.
- Works MSB-first, DIGIT bits per cycle, so the critical path stays short in wide datapaths.
- Valid/ready on input and output. Sits between an operand producer (register file / test stimulus engine) and a result checker.
- The hardware producer of the comparison flags that checker logic consumes.

---
 rtl/serial_le_cmp_pkg.sv | 22 ++
 rtl/serial_le_cmp_digit.sv | 18 +
 rtl/serial_le_cmp.sv | 132 +++++++++++++
 tb/tb_serial_le_cmp.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_le_cmp_pkg.sv
// serial_le_cmp_pkg: shared types and sizing helpers for the serial
// signed comparator (serial_le_cmp and its digit compare).
package serial_le_cmp_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of DIGIT-wide compare steps needed for a WIDTH-bit operand
  function automatic int n_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width able to hold 0..n inclusive
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_le_cmp_digit.sv
// le_cmp_digit: combinational compare of one DIGIT-bit unsigned slice.
// o_diff flags any difference, o_lt flags i_a < i_b.
module le_cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_diff,
  output logic             o_lt
);

  // Single-slice magnitude compare
  always_comb begin
    o_diff = (i_a != i_b);
    o_lt   = (i_a < i_b);
  end

endmodule

// File: rtl/serial_le_cmp.sv
// serial_le_cmp: MSB-first serial signed comparator producing a<=b, a<b,
// a==b with valid/ready on both sides. Operands are biased (MSB inverted)
// at capture so the signed compare becomes an unsigned digit-by-digit scan.
// Optional build macro SERIAL_LE_CMP_EARLY_EXIT_EN: leave RUN the cycle
// after the first differing digit instead of always scanning all digits.
module serial_le_cmp
  import serial_le_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             le,
  output logic             lt,
  output logic             eq
);

  localparam int N  = n_digits(WIDTH, DIGIT);
  localparam int CW = cnt_w(N);
  localparam logic [WIDTH-1:0] MSB_BIAS = WIDTH'(1) << (WIDTH - 1);

  if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_cfg
    $error("serial_le_cmp: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_decided;
  logic             r_lt_int;

  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  logic             w_diff;
  logic             w_lt;
  logic             w_run_done;

  assign w_dig_a = r_a[WIDTH-1 -: DIGIT];
  assign w_dig_b = r_b[WIDTH-1 -: DIGIT];

  le_cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a    (w_dig_a),
    .i_b    (w_dig_b),
    .o_diff (w_diff),
    .o_lt   (w_lt)
  );

`ifdef SERIAL_LE_CMP_EARLY_EXIT_EN
  // Once a digit has differed the answer is fixed, so stop scanning
  assign w_run_done = (r_cnt == CW'(N)) || r_decided;
`else
  // Fixed latency: always scan every digit
  assign w_run_done = (r_cnt == CW'(N));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_state_nxt = RUN;
      RUN:     if (w_run_done) w_state_nxt = DONE;
      DONE:    if (out_ready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: capture biased operands, then scan one digit per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_lt_int  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= a ^ MSB_BIAS;
            r_b       <= b ^ MSB_BIAS;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_lt_int  <= 1'b0;
          end
        end
        RUN: begin
          if (!w_run_done) begin
            // First differing digit (from the MSB side) decides the order
            if (!r_decided && w_diff) begin
              r_decided <= 1'b1;
              r_lt_int  <= w_lt;
            end
            r_a   <= r_a << DIGIT;
            r_b   <= r_b << DIGIT;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: handshakes from state, flags only presented in DONE
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    eq        = 1'b0;
    lt        = 1'b0;
    le        = 1'b0;
    if (r_state == DONE) begin
      eq = ~r_decided;
      lt = r_decided & r_lt_int;
      le = (r_decided & r_lt_int) | ~r_decided;
    end
  end

endmodule

// File: tb/tb_serial_le_cmp.sv
// tb_serial_le_cmp: directed self-checking bench for serial_le_cmp
// (WIDTH=32, DIGIT=4, so 8 digit steps).
module tb_serial_le_cmp;

  localparam int N = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        le;
  logic        lt;
  logic        eq;

  int n_tests = 0;
  int n_fail  = 0;

  serial_le_cmp #(.WIDTH(32), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .le        (le),
    .lt        (lt),
    .eq        (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair, return flags and edges from accept to out_valid.
  // Operands are scrambled right after the accept edge.
  task automatic do_cmp(input logic [31:0] ta, input logic [31:0] tb_,
                        output logic ole, output logic olt, output logic oeq,
                        output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL timeout a=%h b=%h: out_valid=%b required 1", ta, tb_, out_valid);
    end
    ole = le; olt = lt; oeq = eq;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (le !== 1'b0) begin n_fail++; $display("FAIL reset_le got=%b exp=0", le); end
    n_tests++; if (lt !== 1'b0) begin n_fail++; $display("FAIL reset_lt got=%b exp=0", lt); end
    n_tests++; if (eq !== 1'b0) begin n_fail++; $display("FAIL reset_eq got=%b exp=0", eq); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    logic rle, rlt, req; int lat;
    do_cmp(32'd0, 32'd0, rle, rlt, req, lat);
    n_tests++; if ({rle, rlt, req} !== 3'b101) begin n_fail++; $display("FAIL zero_flags got le/lt/eq=%b exp=101", {rle, rlt, req}); end
    n_tests++; if (lat != N + 1) begin n_fail++; $display("FAIL zero_latency got=%0d exp=%0d", lat, N + 1); end
  endtask

  task automatic test_sequence();
    logic [31:0] va [4] = '{32'd1, 32'd1, 32'd1001, 32'd1003};
    logic [31:0] vb [4] = '{32'd0, 32'd1, 32'd1002, 32'd1002};
    logic [2:0]  ex [4] = '{3'b000, 3'b101, 3'b110, 3'b000}; // {le,lt,eq}
    logic rle, rlt, req; int lat;
    for (int i = 0; i < 4; i++) begin
      do_cmp(va[i], vb[i], rle, rlt, req, lat);
      n_tests++;
      if ({rle, rlt, req} !== ex[i]) begin
        n_fail++; $display("FAIL seq%0d a=%0d b=%0d got le/lt/eq=%b exp=%b", i, va[i], vb[i], {rle, rlt, req}, ex[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] vb [3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [2:0]  ex [3] = '{3'b110, 3'b110, 3'b000};
    logic rle, rlt, req; int lat;
    for (int i = 0; i < 3; i++) begin
      do_cmp(va[i], vb[i], rle, rlt, req, lat);
      n_tests++;
      if ({rle, rlt, req} !== ex[i]) begin
        n_fail++; $display("FAIL signed%0d a=%h b=%h got le/lt/eq=%b exp=%b", i, va[i], vb[i], {rle, rlt, req}, ex[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k; int lat; int bad_v, bad_f, bad_r;
    a = 32'd3; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd10; b = 32'd2;   // held valid during the whole wait; must be ignored
    k = 0;
    while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
    bad_v = 0; bad_f = 0; bad_r = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1) bad_v++;
      if ({le, lt, eq} !== 3'b110) bad_f++;
      if (in_ready !== 1'b0) bad_r++;
      @(posedge clk); #1;
    end
    n_tests++; if (bad_v != 0) begin n_fail++; $display("FAIL bp_out_valid dropped %0d cycles exp 0", bad_v); end
    n_tests++; if (bad_f != 0) begin n_fail++; $display("FAIL bp_flags wrong on %0d cycles exp le/lt/eq=110", bad_f); end
    n_tests++; if (bad_r != 0) begin n_fail++; $display("FAIL bp_in_ready high on %0d cycles exp 0", bad_r); end
    out_ready = 1'b1;
    @(posedge clk); #1;      // output handshake edge
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_hs out_valid=%b exp 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_hs in_ready=%b exp 1", in_ready); end
    @(posedge clk); #1;      // accept edge for (10,2)
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    n_tests++; if (lat != N + 1) begin n_fail++; $display("FAIL bp_next_latency got=%0d exp=%0d", lat, N + 1); end
    n_tests++; if ({le, lt, eq} !== 3'b000) begin n_fail++; $display("FAIL bp_next_flags got=%b exp=000", {le, lt, eq}); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic rle, rlt, req; int lat;
    a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    n_tests++; if ({le, lt, eq} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got=%b exp=000", {le, lt, eq}); end
    do_cmp(32'd5, 32'd5, rle, rlt, req, lat);
    n_tests++; if ({rle, rlt, req} !== 3'b101) begin n_fail++; $display("FAIL midrst_5v5 got le/lt/eq=%b exp=101", {rle, rlt, req}); end
  endtask

`ifdef SERIAL_LE_CMP_EARLY_EXIT_EN
  task automatic test_early_exit();
    logic rle, rlt, req; int lat;
    do_cmp(32'h4000_0000, 32'd0, rle, rlt, req, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL ee_latency got=%0d exp=2", lat); end
    n_tests++; if ({rle, rlt, req} !== 3'b000) begin n_fail++; $display("FAIL ee_flags got=%b exp=000", {rle, rlt, req}); end
    do_cmp(32'd7, 32'd7, rle, rlt, req, lat);
    n_tests++; if (lat != N + 1) begin n_fail++; $display("FAIL ee_eq_latency got=%0d exp=%0d", lat, N + 1); end
    n_tests++; if ({rle, rlt, req} !== 3'b101) begin n_fail++; $display("FAIL ee_eq_flags got=%b exp=101", {rle, rlt, req}); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_sequence();
    test_signed();
    test_backpressure();
    test_reset_mid_run();
`ifdef SERIAL_LE_CMP_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
